pc_sequencer: RTL and testbench

//  Owns the program counter of the MonoCPU and sequences instruction fetch/commit.

---
 rtl/pc_sequencer.sv | 95 +++++++++
 tb/tb_pc_sequencer.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program-counter owner for MonoCPU: sequences fetch/exec, drives the next-PC mux select,
// and handles stall, halt and misaligned-target trapping.
module pc_sequencer #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            fetchReq,
  input  logic            fetchAck,
  output logic            instrValid,
  input  logic            brTaken,
  input  logic            jump,
  input  logic [XLEN-1:0] branchTarget,
  input  logic            stall,
  input  logic            halt,
  output logic [XLEN-1:0] pcOut,
  output logic [XLEN-1:0] pcPlus4,
  output logic            MUXopbu,
  output logic            halted,
  output logic            misaligned,
  output logic [XLEN-1:0] instrCount
);

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);
  localparam logic [XLEN-1:0] CNT_ONE = XLEN'(1);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_HALT  = 2'd2,
    S_ERR   = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] cnt_q, cnt_d;
  logic            mis_q, mis_d;

  // Decoded controls are forced low while reset is asserted.
  assign fetchReq   = ~rst & (state_q == S_FETCH);
  assign instrValid = ~rst & (state_q == S_EXEC);
  assign halted     = ~rst & (state_q == S_HALT);
  assign MUXopbu    = ~rst & (state_q == S_EXEC) & ~stall & (brTaken | jump);
  assign pcPlus4    = pc_q + PC_STEP;
  assign pcOut      = pc_q;
  assign instrCount = cnt_q;
  assign misaligned = mis_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    mis_d   = mis_q;
    unique case (state_q)
      S_FETCH: begin
        if (fetchAck) state_d = S_EXEC;
      end
      S_EXEC: begin
        // Priority: stall, then halt, then misaligned taken target, then normal commit.
        if (stall) begin
          state_d = S_EXEC;
        end else if (halt) begin
          state_d = S_HALT;
          cnt_d   = cnt_q + CNT_ONE;
        end else if (MUXopbu && (branchTarget[1:0] != 2'b00)) begin
          state_d = S_ERR;
          mis_d   = 1'b1;
        end else begin
          pc_d    = MUXopbu ? branchTarget : pcPlus4;
          cnt_d   = cnt_q + CNT_ONE;
          state_d = S_FETCH;
        end
      end
      S_HALT:  state_d = S_HALT;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      mis_q   <= mis_d;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a vector table for straight-line, branch, wait and stall
// flow, then hand-written halt, misaligned-trap and PC-wrap sequences.
module tb_pc_sequencer;

  localparam int unsigned XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            fetchReq, fetchAck, instrValid;
  logic            brTaken, jump, stall, halt;
  logic [XLEN-1:0] branchTarget, pcOut, pcPlus4, instrCount;
  logic            MUXopbu, halted, misaligned;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pc_sequencer #(.XLEN(XLEN), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .fetchReq(fetchReq), .fetchAck(fetchAck),
    .instrValid(instrValid), .brTaken(brTaken), .jump(jump),
    .branchTarget(branchTarget), .stall(stall), .halt(halt),
    .pcOut(pcOut), .pcPlus4(pcPlus4), .MUXopbu(MUXopbu), .halted(halted),
    .misaligned(misaligned), .instrCount(instrCount)
  );

  typedef struct {
    logic        ack, br, jmp, stl, hlt;
    logic [31:0] tgt;
    logic        e_freq, e_ival, e_mux, e_halted, e_mis;
    logic [31:0] e_pc, e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ack, input logic br, input logic jmp, input logic stl,
                       input logic hlt, input logic [31:0] tgt);
    fetchAck = ack; brTaken = br; jump = jmp; stall = stl; halt = hlt; branchTarget = tgt;
  endtask

  task automatic add(input logic ack, input logic br, input logic jmp, input logic stl,
                     input logic hlt, input logic [31:0] tgt, input logic freq,
                     input logic ival, input logic mux, input logic [31:0] pc,
                     input logic [31:0] cnt);
    vec_t v;
    v.ack = ack; v.br = br; v.jmp = jmp; v.stl = stl; v.hlt = hlt; v.tgt = tgt;
    v.e_freq = freq; v.e_ival = ival; v.e_mux = mux; v.e_halted = 1'b0; v.e_mis = 1'b0;
    v.e_pc = pc; v.e_cnt = cnt;
    vecs.push_back(v);
  endtask

  task automatic check_outs(input string tag, input logic freq, input logic ival,
                            input logic mux, input logic hl, input logic mis,
                            input logic [31:0] pc, input logic [31:0] cnt);
    logic [31:0] pc4;
    pc4 = pc + 32'd4;
    chk({tag, ".fetchReq"}, 32'(fetchReq), 32'(freq));
    chk({tag, ".instrValid"}, 32'(instrValid), 32'(ival));
    chk({tag, ".MUXopbu"}, 32'(MUXopbu), 32'(mux));
    chk({tag, ".halted"}, 32'(halted), 32'(hl));
    chk({tag, ".misaligned"}, 32'(misaligned), 32'(mis));
    chk({tag, ".pcOut"}, pcOut, pc);
    chk({tag, ".pcPlus4"}, pcPlus4, pc4);
    chk({tag, ".instrCount"}, instrCount, cnt);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0100);
    tick();
    #1 check_outs("reset_held", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    rst = 1'b0;

    // T1: three straight-line instructions
    add(1, 0, 0, 0, 0, 32'h0,   1, 0, 0, 32'h0, 0);
    add(0, 0, 0, 0, 0, 32'h0,   0, 1, 0, 32'h0, 0);
    add(1, 0, 0, 0, 0, 32'h0,   1, 0, 0, 32'h4, 1);
    add(0, 0, 0, 0, 0, 32'h0,   0, 1, 0, 32'h4, 1);
    add(1, 0, 0, 0, 0, 32'h0,   1, 0, 0, 32'h8, 2);
    add(0, 0, 0, 0, 0, 32'h0,   0, 1, 0, 32'h8, 2);
    // T3: ack withheld 5 cycles
    for (int i = 0; i < 5; i++) add(0, 0, 0, 0, 0, 32'h0, 1, 0, 0, 32'hC, 3);
    add(1, 0, 0, 0, 0, 32'h0,   1, 0, 0, 32'hC, 3);
    // T2: taken branch
    add(0, 1, 0, 0, 0, 32'h100, 0, 1, 1, 32'hC, 3);
    add(1, 0, 0, 0, 0, 32'h0,   1, 0, 0, 32'h100, 4);
    // T4: stalled jump, then release
    for (int i = 0; i < 3; i++) add(0, 0, 1, 1, 0, 32'h200, 0, 1, 0, 32'h100, 4);
    add(0, 0, 1, 0, 0, 32'h200, 0, 1, 1, 32'h100, 4);
    add(1, 0, 0, 0, 0, 32'h0,   1, 0, 0, 32'h200, 5);
    // fetchAck is ignored in EXEC
    add(1, 1, 0, 0, 0, 32'h10,  0, 1, 1, 32'h200, 5);
    add(1, 0, 0, 0, 0, 32'h0,   1, 0, 0, 32'h10, 6);

    foreach (vecs[i]) begin
      drive(vecs[i].ack, vecs[i].br, vecs[i].jmp, vecs[i].stl, vecs[i].hlt, vecs[i].tgt);
      #1;
      check_outs($sformatf("vec%0d", i), vecs[i].e_freq, vecs[i].e_ival, vecs[i].e_mux,
                 vecs[i].e_halted, vecs[i].e_mis, vecs[i].e_pc, vecs[i].e_cnt);
      tick();
    end

    // T5: halt beats taken branch; counts, PC held, sticky until reset
    drive(0, 1, 0, 0, 1, 32'h300);
    tick();
    drive(1, 1, 1, 0, 0, 32'h300);
    #1 check_outs("halt_0", 0, 0, 0, 1, 0, 32'h10, 7);
    tick(); tick();
    check_outs("halt_2", 0, 0, 0, 1, 0, 32'h10, 7);
    rst = 1'b1;
    #1 check_outs("halt_rst_hi", 0, 0, 0, 0, 0, 32'h10, 7);
    tick();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 32'h0);
    #1 check_outs("halt_after_rst", 1, 0, 0, 0, 0, 32'h0, 0);

    // T6: misaligned jump target traps into ERR
    drive(1, 0, 0, 0, 0, 32'h0);
    tick();
    drive(0, 0, 1, 0, 0, 32'h102);
    tick();
    drive(1, 1, 1, 0, 0, 32'h0);
    #1 check_outs("err_0", 0, 0, 0, 0, 1, 32'h0, 0);
    tick(); tick();
    check_outs("err_2", 0, 0, 0, 0, 1, 32'h0, 0);

    // reset mid-EXEC: the pending branch must not commit
    rst = 1'b1; tick(); rst = 1'b0;
    drive(1, 0, 0, 0, 0, 32'h0);
    tick();
    drive(0, 1, 0, 0, 0, 32'h40);
    rst = 1'b1; tick(); rst = 1'b0;
    drive(0, 0, 0, 0, 0, 32'h0);
    #1 check_outs("rst_mid_exec", 1, 0, 0, 0, 0, 32'h0, 0);

    // PC wrap: jump to 0xFFFFFFFC then fall through to 0
    drive(1, 0, 0, 0, 0, 32'h0); tick();
    drive(0, 0, 1, 0, 0, 32'hFFFF_FFFC); tick();
    drive(1, 0, 0, 0, 0, 32'h0);
    #1 check_outs("wrap_top", 1, 0, 0, 0, 0, 32'hFFFF_FFFC, 1);
    tick();
    drive(0, 0, 0, 0, 0, 32'h0); tick();
    check_outs("wrap_zero", 1, 0, 0, 0, 0, 32'h0, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
